// File: rtl/sccb_arbiter_if.sv
// Bundle between the two register-access requesters, the arbiter and the
// single SCCB/I2C master it drives.
interface sccb_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_rw;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        i2c_start;
  logic        i2c_wr_en;
  logic        i2c_rd_en;
  logic [15:0] i2c_byte_addr;
  logic [7:0]  i2c_wr_data;
  logic        i2c_end;
  logic [7:0]  i2c_rd_data;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  i2c_end, i2c_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output i2c_start, i2c_wr_en, i2c_rd_en,
    output i2c_byte_addr, i2c_wr_data
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    output i2c_end, i2c_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  i2c_start, i2c_wr_en, i2c_rd_en,
    input  i2c_byte_addr, i2c_wr_data
  );
endinterface

// File: rtl/sccb_arbiter.sv
// Two-port arbiter sharing one SCCB/I2C master: grant, launch, watchdog,
// respond, then hold off for an inter-transaction gap.
module sccb_arbiter #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 8,
  parameter int CNT_W       = 13
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        prio_lock,
  sccb_arbiter_if.master bus,
  output logic        busy,
  output logic        grant_id,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_END,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]       r_req_ready;
  logic [1:0]       r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_start;
  logic             r_wr_en;
  logic             r_rd_en;
  logic [15:0]      r_addr;
  logic [7:0]       r_wdata;
  logic             r_rw;
  logic             r_busy;
  logic             r_grant;
  logic             r_last;
  logic [7:0]       r_err_cnt;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_gnt;
  logic w_launch;
  logic w_done_ok;
  logic w_done_to;
  logic w_cnt_inc;
  logic w_stray;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_gnt       = 1'b0;
    w_launch    = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_stray     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stray = bus.i2c_end;
        if (|bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
          // Contention: lock favours port 0, else round-robin.
          if (&bus.req_valid) w_gnt = prio_lock ? 1'b0 : ~r_last;
          else                w_gnt = bus.req_valid[1];
        end
      end
      START: begin
        w_stray     = bus.i2c_end;
        w_launch    = 1'b1;
        w_state_nxt = WAIT_END;
      end
      WAIT_END: begin
        if (bus.i2c_end) begin
          w_done_ok   = 1'b1;
          w_state_nxt = GAP;
        end else if (r_cnt == TO_LAST) begin
          w_done_to   = 1'b1;
          w_state_nxt = GAP;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      GAP: begin
        w_stray = bus.i2c_end;
        if (r_cnt == GAP_LAST) w_state_nxt = IDLE;
        else                   w_cnt_inc   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_start     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_grant     <= 1'b0;
      r_last      <= 1'b1;
      r_err_cnt   <= '0;
      r_cnt       <= '0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_start     <= 1'b0;
      r_busy      <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_req_ready <= w_gnt ? 2'b10 : 2'b01;
        r_rw        <= bus.req_rw[w_gnt];
        r_addr      <= w_gnt ? bus.req_addr[31:16]
                             : bus.req_addr[15:0];
        r_wdata     <= w_gnt ? bus.req_wdata[15:8]
                             : bus.req_wdata[7:0];
        r_grant     <= w_gnt;
        r_last      <= w_gnt;
      end
      if (w_launch) begin
        r_start <= 1'b1;
        r_rd_en <= r_rw;
        r_wr_en <= ~r_rw;
        r_cnt   <= '0;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_done_ok || w_done_to) begin
        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
        r_rsp_rdata <= (w_done_ok && r_rw) ? bus.i2c_rd_data : 8'h00;
        r_rsp_err   <= w_done_to;
        r_rd_en     <= 1'b0;
        r_wr_en     <= 1'b0;
        r_cnt       <= '0;
      end
      if ((w_done_to || w_stray) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.req_ready     = r_req_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.i2c_start     = r_start;
  assign bus.i2c_wr_en     = r_wr_en;
  assign bus.i2c_rd_en     = r_rd_en;
  assign bus.i2c_byte_addr = r_addr;
  assign bus.i2c_wr_data   = r_wdata;
  assign busy              = r_busy;
  assign grant_id          = r_grant;
  assign err_cnt           = r_err_cnt;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter: vector table of single transactions plus
// hand-written arbitration, reset and saturation sequences.
module tb_sccb_arbiter;
  localparam int TO = 64;
  localparam int GP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prio_lock = 1'b0;
  logic       busy;
  logic       grant_id;
  logic [7:0] err_cnt;

  sccb_arbiter_if bus ();

  sccb_arbiter #(
    .TIMEOUT_CYC(TO),
    .GAP_CYC(GP),
    .CNT_W(13)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .prio_lock(prio_lock),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         port;
    bit         rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          end_at;
    logic [7:0]  rd;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[7];

  task automatic wait_any(output int g);
    g = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        g = bus.req_ready[1] ? 1 : 0;
        break;
      end
    end
    if (g < 0) chk("ready_wait_expired", 0, 1);
  endtask

  task automatic serve(input int end_at, input logic [7:0] rd,
                       output int k_rsp, output logic [1:0] rv);
    k_rsp = -1;
    rv = 2'b00;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        k_rsp = k;
        rv = bus.rsp_valid;
        break;
      end
      bus.i2c_end     = (k == end_at);
      bus.i2c_rd_data = rd;
    end
    bus.i2c_end = 1'b0;
    if (k_rsp < 0) chk("rsp_wait_expired", 0, 1);
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int g;
    int k_rsp;
    int exp_k;
    int hold_bad;
    @(negedge clk);
    bus.req_valid[v.port] = 1'b1;
    bus.req_rw[v.port]    = v.rw;
    if (v.port == 1) begin
      bus.req_addr[31:16] = v.addr;
      bus.req_wdata[15:8] = v.wdata;
    end else begin
      bus.req_addr[15:0] = v.addr;
      bus.req_wdata[7:0] = v.wdata;
    end
    wait_any(g);
    chk($sformatf("v%0d_grant", idx), g, v.port);
    chk($sformatf("v%0d_grant_id", idx), grant_id, v.port);
    bus.req_valid = 2'b00;
    bus.req_addr  = 32'hDEAD_BEEF;
    bus.req_wdata = 16'hFFFF;
    bus.req_rw    = ~bus.req_rw;
    exp_k = (v.end_at >= 0 && v.end_at < TO) ? v.end_at + 1 : TO;
    hold_bad = 0;
    k_rsp = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0)
        chk($sformatf("v%0d_start", idx), bus.i2c_start, 1);
      if (bus.rsp_valid != 2'b00) begin
        k_rsp = k;
        break;
      end
      if (k > 0 && bus.i2c_start !== 1'b0) hold_bad++;
      if (bus.i2c_byte_addr !== v.addr) hold_bad++;
      if (bus.i2c_wr_data !== v.wdata) hold_bad++;
      if (bus.i2c_rd_en !== v.rw) hold_bad++;
      if (bus.i2c_wr_en !== !v.rw) hold_bad++;
      bus.i2c_end     = (k == v.end_at);
      bus.i2c_rd_data = v.rd;
    end
    bus.i2c_end = 1'b0;
    chk($sformatf("v%0d_hold_errs", idx), hold_bad, 0);
    chk($sformatf("v%0d_rsp_cycle", idx), k_rsp, exp_k);
    chk($sformatf("v%0d_rsp_valid", idx), bus.rsp_valid,
        (v.port == 1) ? 2'b10 : 2'b01);
    chk($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), bus.rsp_err, v.exp_err);
    chk($sformatf("v%0d_en_gap", idx),
        {bus.i2c_rd_en, bus.i2c_wr_en}, 0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_pulse", idx), bus.rsp_valid, 0);
    chk($sformatf("v%0d_rdata_held", idx), bus.rsp_rdata, v.exp_rdata);
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("idle_wait_expired", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, bus.req_ready, 0);
    chk({nm, "_rsp"}, {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 0);
    chk({nm, "_i2c_ctl"},
        {bus.i2c_start, bus.i2c_wr_en, bus.i2c_rd_en}, 0);
    chk({nm, "_i2c_data"}, {bus.i2c_byte_addr, bus.i2c_wr_data}, 0);
    chk({nm, "_status"}, {busy, grant_id, err_cnt}, 0);
  endtask

  initial begin
    int g;
    int k;
    int t_rsp;
    int bad;
    logic [1:0] rv;
    int exp_order[4];

    vt[0] = '{0, 1'b0, 16'h3008, 8'h82, 50, 8'h00, 8'h00, 1'b0};
    vt[1] = '{1, 1'b1, 16'h300A, 8'h00, 20, 8'h56, 8'h56, 1'b0};
    vt[2] = '{0, 1'b1, 16'h300B, 8'h11, 5, 8'hA5, 8'hA5, 1'b0};
    vt[3] = '{1, 1'b0, 16'h3503, 8'h07, 0, 8'hFF, 8'h00, 1'b0};
    vt[4] = '{0, 1'b1, 16'h3100, 8'h00, -1, 8'h99, 8'h00, 1'b1};
    vt[5] = '{1, 1'b1, 16'h300C, 8'h00, 63, 8'h3C, 8'h3C, 1'b0};
    vt[6] = '{0, 1'b0, 16'h3820, 8'h40, 62, 8'h00, 8'h00, 1'b0};
    exp_order = '{0, 1, 0, 1};

    bus.req_valid   = 2'b00;
    bus.req_rw      = 2'b00;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.i2c_end     = 1'b0;
    bus.i2c_rd_data = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_txn(vt[i], i);
      wait_idle();
    end
    chk("err_cnt_after_table", err_cnt, 1);

    // Round-robin with both ports always requesting
    pulse_reset();
    bus.req_rw    = 2'b00;
    bus.req_valid = 2'b11;
    t_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_any(g);
      chk($sformatf("rr%0d_grant", i), g, exp_order[i]);
      if (i > 0)
        chk($sformatf("rr%0d_gap", i), cyc - t_rsp, GP + 1);
      serve(3, 8'h00, k, rv);
      t_rsp = cyc;
      chk($sformatf("rr%0d_rsp_port", i), rv,
          (exp_order[i] == 1) ? 2'b10 : 2'b01);
    end

    // Priority lock holds port 0 until released
    prio_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_any(g);
      chk($sformatf("lock%0d_grant", i), g, 0);
      if (i == 2) prio_lock = 1'b0;
      serve(2, 8'h00, k, rv);
    end
    wait_any(g);
    chk("unlock_grant", g, 1);
    bus.req_valid = 2'b00;
    serve(2, 8'h00, k, rv);
    wait_idle();

    // Reset mid-transaction, then a stray end while idle
    @(negedge clk);
    bus.req_valid = 2'b01;
    wait_any(g);
    bus.req_valid = 2'b00;
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00 || busy) bad++;
    end
    chk("midrst_no_rsp", bad, 0);
    bus.i2c_end = 1'b1;
    @(negedge clk);
    bus.i2c_end = 1'b0;
    @(negedge clk);
    chk("stray_err_cnt", err_cnt, 1);
    chk("stray_quiet", {busy, bus.rsp_valid, bus.i2c_start}, 0);

    // Forced timeouts drive err_cnt into saturation
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.req_valid = 2'b10;
      wait_any(g);
      bus.req_valid = 2'b00;
      serve(-1, 8'h00, k, rv);
      if (i == 252) chk("sat_err_cnt_254", err_cnt, 254);
      if (i == 299) begin
        chk("sat_last_rsp_cycle", k, TO);
        chk("sat_last_err", bus.rsp_err, 1);
      end
    end
    chk("sat_err_cnt_255", err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
